// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_OWNED = 1'b1;

  // Minimum of 1 so that index registers never collapse to zero width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of per-master request/response buses and the shared slave bus.
interface wb_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Wishbone B.4 classic: a master holds cyc for the whole bus cycle and stb
  // for each beat; a beat completes in the cycle where ack, err or rty is seen
  // with stb high. cyc/stb must stay stable until that termination arrives.
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdat;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel;
  logic [NUM_MASTERS-1:0]            m_we, m_cyc, m_stb, m_cti, m_bte;
  logic [DATA_WIDTH-1:0]             m_rdat;
  logic [NUM_MASTERS-1:0]            m_ack, m_err, m_rty;

  logic [ADDR_WIDTH-1:0] s_adr;
  logic [DATA_WIDTH-1:0] s_wdat, s_rdat;
  logic [SEL_WIDTH-1:0]  s_sel;
  logic                  s_we, s_cyc, s_stb, s_cti, s_bte;
  logic                  s_ack, s_err, s_rty;

  logic [NUM_MASTERS-1:0] grant;

  // slave: the arbiter, which is the target of the masters' requests.
  modport slave (
    input  m_adr, m_wdat, m_sel, m_we, m_cyc, m_stb, m_cti, m_bte,
    output m_rdat, m_ack, m_err, m_rty,
    output s_adr, s_wdat, s_sel, s_we, s_cyc, s_stb, s_cti, s_bte,
    input  s_rdat, s_ack, s_err, s_rty,
    output grant
  );

  // master: the environment driving master requests and slave responses.
  modport master (
    output m_adr, m_wdat, m_sel, m_we, m_cyc, m_stb, m_cti, m_bte,
    input  m_rdat, m_ack, m_err, m_rty,
    input  s_adr, s_wdat, s_sel, s_we, s_cyc, s_stb, s_cti, s_bte,
    output s_rdat, s_ack, s_err, s_rty,
    input  grant
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int LW          = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [LW-1:0]          last_i,
  output logic [NUM_MASTERS-1:0] winner_o,
  output logic [LW-1:0]          winner_idx_o,
  output logic                   valid_o
);

  logic [LW-1:0] cand;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    valid_o      = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = LW'((int'(last_i) + k) % NUM_MASTERS);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        winner_idx_o   = cand;
        winner_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter granting whole Wishbone bus cycles to one of several
// masters, with a watchdog that terminates beats the slave never answers.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  wb_arbiter_if.slave bus,
  output arb_state_t dbg_state_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int LW        = clog2(NUM_MASTERS);
  localparam int TW        = clog2(TIMEOUT_CYCLES);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [TW-1:0]          wd_cnt_q, wd_cnt_d;
  logic                   wd_err_q, wd_err_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [LW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   owned, s_resp, waiting, wd_fire;

  wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .LW(LW)) u_picker (
    .req_i        (bus.m_cyc),
    .last_i       (last_q),
    .winner_o     (pick_onehot),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

  assign owned   = (state_q == ARB_OWNED);
  assign s_resp  = bus.s_ack | bus.s_err | bus.s_rty;
  assign waiting = owned & bus.s_stb & ~s_resp;
  assign wd_fire = waiting & (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = '0;
    wd_err_d = 1'b0;
    if (!owned) begin
      if (pick_valid) begin
        state_d = ARB_OWNED;
        grant_d = pick_onehot;
        last_d  = pick_idx;
      end
    end else begin
      if (!(|(bus.m_cyc & grant_q))) begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
      if (wd_fire) wd_err_d = 1'b1;
      else if (waiting) wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      last_q   <= LW'(NUM_MASTERS - 1);
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  // s_cyc follows the registered state only, so no m_cyc edge reaches it combinationally.
  always_comb begin
    bus.s_cyc  = owned;
    bus.s_adr  = '0;
    bus.s_wdat = '0;
    bus.s_sel  = '0;
    bus.s_we   = 1'b0;
    bus.s_stb  = 1'b0;
    bus.s_cti  = 1'b0;
    bus.s_bte  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        bus.s_adr  = bus.m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_wdat = bus.m_wdat[i*DATA_WIDTH +: DATA_WIDTH];
        bus.s_sel  = bus.m_sel[i*SEL_WIDTH +: SEL_WIDTH];
        bus.s_we   = bus.m_we[i];
        bus.s_stb  = bus.m_stb[i];
        bus.s_cti  = bus.m_cti[i];
        bus.s_bte  = bus.m_bte[i];
      end
    end
  end

  // A real slave response in the watchdog cycle takes precedence over the synthetic err.
  always_comb begin
    bus.m_ack = '0;
    bus.m_err = '0;
    bus.m_rty = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_ack[i] = grant_q[i] & bus.s_ack;
      bus.m_rty[i] = grant_q[i] & bus.s_rty;
      bus.m_err[i] = grant_q[i] & (bus.s_err | (wd_err_q & ~bus.s_ack & ~bus.s_rty));
    end
  end

  assign bus.m_rdat  = bus.s_rdat;
  assign bus.grant   = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: abstract bus-ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int NM   = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TO   = 4;
  localparam int AALL = NM * AW;
  localparam int DALL = NM * DW;
  localparam int SALL = NM * SW;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b1;
  arb_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  wb_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mdl_owner;   // -1 when nobody owns the bus
  int mdl_last;
  int mdl_wait;    // consecutive unanswered stb cycles
  bit mdl_pulse;   // watchdog err due this cycle

  function automatic bit bit_at(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int rr_pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) begin
      int idx;
      idx = (last + k) % NM;
      if (bit_at(req, idx)) return idx;
    end
    return -1;
  endfunction

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mdl_owner <= -1;
      mdl_last  <= NM - 1;
      mdl_wait  <= 0;
      mdl_pulse <= 1'b0;
    end else if (mdl_owner < 0) begin
      mdl_wait  <= 0;
      mdl_pulse <= 1'b0;
      if (rr_pick(bus.m_cyc, mdl_last) >= 0) begin
        mdl_owner <= rr_pick(bus.m_cyc, mdl_last);
        mdl_last  <= rr_pick(bus.m_cyc, mdl_last);
      end
    end else begin
      if (!bit_at(bus.m_cyc, mdl_owner)) mdl_owner <= -1;
      if (bit_at(bus.m_stb, mdl_owner) && !(bus.s_ack || bus.s_err || bus.s_rty)) begin
        if (mdl_wait + 1 == TO) begin
          mdl_pulse <= 1'b1;
          mdl_wait  <= 0;
        end else begin
          mdl_pulse <= 1'b0;
          mdl_wait  <= mdl_wait + 1;
        end
      end else begin
        mdl_pulse <= 1'b0;
        mdl_wait  <= 0;
      end
    end
  end

  function automatic logic [63:0] own_bit(input bit cond);
    return (mdl_owner >= 0 && cond) ? (64'd1 << mdl_owner) : 64'd0;
  endfunction

  function automatic logic [63:0] own_field(input logic [AALL-1:0] v, input int w);
    logic [AALL-1:0] t;
    logic [63:0]     mask;
    if (mdl_owner < 0) return 64'd0;
    t    = v >> (mdl_owner * w);
    mask = (64'd1 << w) - 64'd1;
    return 64'(t) & mask;
  endfunction

  always @(negedge wb_clk) begin
    chk("grant", bus.grant, own_bit(1'b1));
    chk("state", dbg_state, (mdl_owner >= 0) ? ARB_OWNED : ARB_IDLE);
    chk("s_cyc", bus.s_cyc, mdl_owner >= 0);
    chk("s_stb", bus.s_stb, mdl_owner >= 0 && bit_at(bus.m_stb, mdl_owner));
    chk("s_we",  bus.s_we,  mdl_owner >= 0 && bit_at(bus.m_we, mdl_owner));
    chk("s_cti", bus.s_cti, mdl_owner >= 0 && bit_at(bus.m_cti, mdl_owner));
    chk("s_bte", bus.s_bte, mdl_owner >= 0 && bit_at(bus.m_bte, mdl_owner));
    chk("s_adr", bus.s_adr, own_field(bus.m_adr, AW));
    chk("s_wdat", bus.s_wdat, own_field(AALL'(bus.m_wdat), DW));
    chk("s_sel", bus.s_sel, own_field(AALL'(bus.m_sel), SW));
    chk("m_rdat", bus.m_rdat, bus.s_rdat);
    chk("m_ack", bus.m_ack, own_bit(bus.s_ack));
    chk("m_rty", bus.m_rty, own_bit(bus.s_rty));
    chk("m_err", bus.m_err, own_bit(bus.s_err || (mdl_pulse && !bus.s_ack && !bus.s_rty)));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_all();
    bus.m_adr  = '0; bus.m_wdat = '0; bus.m_sel = '0;
    bus.m_we   = '0; bus.m_cyc  = '0; bus.m_stb = '0;
    bus.m_cti  = '0; bus.m_bte  = '0;
    bus.s_rdat = '0; bus.s_ack  = 1'b0; bus.s_err = 1'b0; bus.s_rty = 1'b0;
  endtask

  task automatic set_m(input int i, input bit on, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] wdat);
    logic [NM-1:0]   bm;
    logic [AALL-1:0] am;
    logic [DALL-1:0] dm;
    logic [SALL-1:0] sm;
    bm = NM'(1) << i;
    am = AALL'({AW{1'b1}}) << (i * AW);
    dm = DALL'({DW{1'b1}}) << (i * DW);
    sm = SALL'({SW{1'b1}}) << (i * SW);
    bus.m_cyc  = on ? (bus.m_cyc | bm) : (bus.m_cyc & ~bm);
    bus.m_stb  = on ? (bus.m_stb | bm) : (bus.m_stb & ~bm);
    bus.m_cti  = on ? (bus.m_cti | bm) : (bus.m_cti & ~bm);
    bus.m_we   = (on && we) ? (bus.m_we | bm) : (bus.m_we & ~bm);
    bus.m_bte  = (on && we) ? (bus.m_bte | bm) : (bus.m_bte & ~bm);
    bus.m_adr  = (bus.m_adr & ~am) | ((AALL'(adr) << (i * AW)) & am);
    bus.m_wdat = (bus.m_wdat & ~dm) | ((DALL'(wdat) << (i * DW)) & dm);
    bus.m_sel  = on ? (bus.m_sel | sm) : (bus.m_sel & ~sm);
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    step();
    step();
    wb_rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int owner;
    int budget;
    idle_all();
    #1 wb_rst_n = 1'b0;
    step();
    step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_s_cyc", bus.s_cyc, 0);
    chk("rst_m_ack", bus.m_ack, 0);
    wb_rst_n = 1'b1;
    step();

    // single master write, one-cycle grant latency
    set_m(0, 1'b1, 1'b1, 32'h100, 32'hA5A5_0001);
    #1 chk("t1_no_same_cycle", bus.s_cyc, 0);
    step();
    chk("t1_s_cyc", bus.s_cyc, 1);
    chk("t1_s_adr", bus.s_adr, 32'h100);
    chk("t1_s_wdat", bus.s_wdat, 32'hA5A5_0001);
    chk("t1_grant", bus.grant, 2'b01);
    bus.s_ack = 1'b1;
    bus.s_rdat = 32'h1234_5678;
    #1 chk("t1_m_ack", bus.m_ack, 2'b01);
    step();
    bus.s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t1_released", bus.grant, 0);

    // contention from reset: m0 first, one idle cycle, then m1
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h200, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h300, 32'h0);
    step();
    chk("t2_m0_first", bus.grant, 2'b01);
    chk("t2_s_adr_m0", bus.s_adr, 32'h200);
    bus.s_ack = 1'b1;
    step();
    bus.s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t2_gap", bus.grant, 0);
    chk("t2_gap_s_cyc", bus.s_cyc, 0);
    step();
    chk("t2_m1_next", bus.grant, 2'b10);
    chk("t2_s_adr_m1", bus.s_adr, 32'h300);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // fairness under continuous requests: 0,1,0,1
    set_m(0, 1'b1, 1'b1, 32'h10, 32'hAAAA_0000);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'hBBBB_0000);
    for (int g = 0; g < 4; g++) begin
      budget = 0;
      while (bus.grant == 0 && budget < 6) begin
        step();
        budget++;
      end
      owner = g % 2;
      chk("t3_fair_grant", bus.grant, (owner == 0) ? 2'b01 : 2'b10);
      repeat (3) step();
      set_m(owner, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      set_m(owner, 1'b1, owner == 0, (owner == 0) ? 32'h10 : 32'h20, 32'hCCCC_0000 + g);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // isolation: m1 owns, m0 waits with cyc high
    set_m(1, 1'b1, 1'b0, 32'h400, 32'h0);
    step();
    chk("t4_m1_owner", bus.grant, 2'b10);
    set_m(0, 1'b1, 1'b1, 32'h404, 32'h5555_0000);
    for (int j = 0; j < 3; j++) begin
      bus.s_rdat = 32'hC0DE_0000 + j;
      bus.s_ack = (j < 2);
      bus.s_rty = (j == 2);
      #1;
      chk("t4_ack_m1_only", bus.m_ack, (j < 2) ? 2'b10 : 2'b00);
      chk("t4_rty_m1_only", bus.m_rty, (j == 2) ? 2'b10 : 2'b00);
      chk("t4_rdat", bus.m_rdat, 32'hC0DE_0000 + j);
      chk("t4_s_adr_m1", bus.s_adr, 32'h400);
      step();
    end
    bus.s_ack = 1'b0;
    bus.s_rty = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("t4_m0_after", bus.grant, 2'b01);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // watchdog: no response, err 4 cycles after stb and again 4 later
    set_m(0, 1'b1, 1'b0, 32'h500, 32'h0);
    step();
    for (int j = 0; j <= 8; j++) begin
      chk("t5_wd_err", bus.m_err, (j == 4 || j == 8) ? 2'b01 : 2'b00);
      step();
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // real ack in the watchdog cycle wins
    set_m(0, 1'b1, 1'b0, 32'h504, 32'h0);
    step();
    repeat (4) step();
    bus.s_ack = 1'b1;
    #1;
    chk("t5b_err_suppressed", bus.m_err, 2'b00);
    chk("t5b_ack_wins", bus.m_ack, 2'b01);
    step();
    bus.s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // slave responses while idle are dropped
    bus.s_ack = 1'b1;
    bus.s_err = 1'b1;
    #1;
    chk("idle_no_ack", bus.m_ack, 2'b00);
    chk("idle_no_err", bus.m_err, 2'b00);
    step();
    bus.s_ack = 1'b0;
    bus.s_err = 1'b0;

    // asynchronous reset mid-transfer
    set_m(1, 1'b1, 1'b1, 32'h600, 32'hDEAD_BEEF);
    step();
    chk("t6_m1_owner", bus.grant, 2'b10);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("t6_s_cyc_async", bus.s_cyc, 0);
    chk("t6_grant_async", bus.grant, 0);
    chk("t6_m_err_async", bus.m_err, 0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    wb_rst_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h700, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h704, 32'h0);
    step();
    chk("t6_m0_first", bus.grant, 2'b01);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
